// File: rtl/irq_prio_ctrl.sv
// Clocked interrupt priority controller: edge capture, per-channel masking and a
// valid/ack grant. Define IRQ_RR_EN for round-robin instead of fixed lowest-index priority.
module irq_prio_ctrl #(
  parameter int N_CH = 27,
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  output logic [N_CH-1:0] mask_q,
  output logic [N_CH-1:0] pending_q,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack
);

  generate
    if (N_CH < 2 || N_CH > 64) begin : g_bad_nch
      $error("irq_prio_ctrl: N_CH must be in 2..64");
    end
    if (ID_W != $clog2(N_CH)) begin : g_bad_idw
      $error("irq_prio_ctrl: ID_W must equal $clog2(N_CH)");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t          r_state;
  logic [N_CH-1:0] r_prev;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_mask;
  logic            r_valid;
  logic [ID_W-1:0] r_id;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_pending_next;
  logic [N_CH-1:0] w_eligible;
  logic [N_CH-1:0] w_search;
  logic [N_CH-1:0] w_low;
  logic [ID_W-1:0] w_term [N_CH];
  logic [ID_W-1:0] w_acc  [N_CH];
  logic [ID_W-1:0] w_win_id;
  logic            w_ack_fire;

  assign w_ack_fire = (r_state == ST_REQ) && irq_ack;
  assign w_eligible = r_pending & ~r_mask;

  // A rise on the same edge as the clear of that bit survives (set wins).
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign w_rise[gi]         = irq_in[gi] & ~r_prev[gi];
      assign w_clr[gi]          = w_ack_fire && (r_id == ID_W'(gi));
      assign w_pending_next[gi] = (r_pending[gi] & ~w_clr[gi]) | w_rise[gi];
    end
  endgenerate

`ifdef IRQ_RR_EN
  localparam logic [ID_W:0] N_CH_W = (ID_W+1)'(N_CH);

  logic [ID_W-1:0]   r_rr_ptr;
  logic [2*N_CH-1:0] w_dbl;
  logic [ID_W:0]     w_sum;

  // Rotate so the pointer channel sits at bit 0, then map the hit back.
  assign w_dbl    = {w_eligible, w_eligible};
  assign w_search = N_CH'(w_dbl >> r_rr_ptr);
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_acc[N_CH-1]};
  assign w_win_id = (w_sum >= N_CH_W) ? ID_W'(w_sum - N_CH_W) : w_sum[ID_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_ack_fire) begin
      r_rr_ptr <= (r_id == ID_W'(N_CH-1)) ? '0 : r_id + 1'b1;
    end
  end
`else
  assign w_search = w_eligible;
  assign w_win_id = w_acc[N_CH-1];
`endif

  // Isolate the lowest set bit and encode it as an OR of per-bit index terms.
  assign w_low = w_search & (~w_search + {{(N_CH-1){1'b0}}, 1'b1});

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_enc
      assign w_term[gi] = w_low[gi] ? ID_W'(gi) : '0;
      if (gi == 0) begin : g_first
        assign w_acc[gi] = w_term[gi];
      end else begin : g_rest
        assign w_acc[gi] = w_acc[gi-1] | w_term[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      r_prev    <= irq_in;
      r_pending <= w_pending_next;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_eligible) begin
            r_id    <= w_win_id;
            r_valid <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mask_q    = r_mask;
  assign pending_q = r_pending;
  assign irq_valid = r_valid;
  assign irq_id    = r_id;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_irq_prio_ctrl;
  localparam int N  = 27;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  pending_q;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          irq_ack;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  irq_prio_ctrl #(.N_CH(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .mask_q(mask_q), .pending_q(pending_q),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural model: state held as plain vectors/ints, winner found by a scan.
  logic [N-1:0] m_prev, m_pend, m_mask, m_rise, m_clr, m_elig;
  bit           m_valid;
  int           m_id, m_rr;

  function automatic int pick(input logic [N-1:0] e, input int start);
    for (int k = 0; k < N; k++) begin
      if (e[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = '0; m_pend = '0; m_mask = '1;
      m_valid = 1'b0; m_id = 0; m_rr = 0;
    end else begin
      m_rise = irq_in & ~m_prev;
      m_clr  = '0;
      m_elig = m_pend & ~m_mask;
      if (m_valid) begin
        if (irq_ack) begin
          m_clr = bitv(m_id);
          m_valid = 1'b0;
          m_rr = (m_id + 1) % N;
        end
      end else if (m_elig != '0) begin
`ifdef IRQ_RR_EN
        m_id = pick(m_elig, m_rr);
`else
        m_id = pick(m_elig, 0);
`endif
        m_valid = 1'b1;
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_prev = irq_in;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en && !rst) begin
      check("mdl_valid", irq_valid, m_valid);
      check("mdl_pending", pending_q, m_pend);
      check("mdl_mask", mask_q, m_mask);
      if (m_valid) check("mdl_id", irq_id, m_id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!irq_valid && k < 20) begin
      step();
      k++;
    end
    check("wait_valid", irq_valid, 1);
  endtask

  task automatic do_ack();
    $display("grant served: id=%0d", irq_id);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  logic [N-1:0] all_ones;
  int exp_order [3];
  int rr_exp [4];
  int acked;

  initial begin
    all_ones = '1;
`ifdef IRQ_RR_EN
    exp_order = '{9, 26, 3};
`else
    exp_order = '{3, 9, 26};
`endif
    rr_exp = '{2, 4, 2, 4};
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0;
    #3;
    check("rst_mask", mask_q, all_ones);
    check("rst_pending", pending_q, 0);
    check("rst_valid", irq_valid, 0);
    check("rst_id", irq_id, 0);
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic grant
    mask_we = 1'b1; mask_wdata = '0; step(); mask_we = 1'b0;
    check("basic_mask0", mask_q, 0);
    irq_in = bitv(5); step();
    check("basic_pend5", pending_q, bitv(5));
    check("basic_notyet", irq_valid, 0);
    irq_in = '0; step();
    check("basic_valid", irq_valid, 1);
    check("basic_id", irq_id, 5);
    do_ack();
    check("basic_ack_valid", irq_valid, 0);
    check("basic_ack_pend", pending_q, 0);

    // Ack in IDLE is ignored
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("idle_ack", irq_valid, 0);

    // Priority order with an idle gap between grants
    irq_in = bitv(3) | bitv(9) | bitv(26); step();
    irq_in = '0; step();
    for (int i = 0; i < 3; i++) begin
      check("prio_valid", irq_valid, 1);
      check("prio_id", irq_id, exp_order[i]);
      do_ack();
      check("prio_gap", irq_valid, 0);
      if (i < 2) step();
    end
    check("prio_drained", pending_q, 0);

    // Masking
    mask_we = 1'b1; mask_wdata = bitv(3); step(); mask_we = 1'b0;
    irq_in = bitv(3) | bitv(9); step();
    irq_in = '0; step();
    check("mask_id9", irq_id, 9);
    do_ack();
    check("mask_pend3", pending_q, bitv(3));
    step();
    check("mask_held", irq_valid, 0);
    mask_we = 1'b1; mask_wdata = '0; step(); mask_we = 1'b0;
    check("mask_write_edge", irq_valid, 0);
    step();
    check("unmask_valid", irq_valid, 1);
    check("unmask_id3", irq_id, 3);
    do_ack();

    // Simultaneous set and clear on channel 7
    irq_in = bitv(7); step();
    irq_in = '0; step();
    check("sc_id7", irq_id, 7);
    irq_in = bitv(7); irq_ack = 1'b1;
    $display("grant served: id=%0d", irq_id);
    step();
    irq_ack = 1'b0; irq_in = '0;
    check("sc_pend7", pending_q, bitv(7));
    check("sc_valid_low", irq_valid, 0);
    step();
    check("sc_regrant", irq_valid, 1);
    check("sc_regrant_id", irq_id, 7);
    do_ack();

`ifdef IRQ_RR_EN
    // Round-robin alternation
    rst = 1'b1; step(); rst = 1'b0;
    mask_we = 1'b1; mask_wdata = '0; step(); mask_we = 1'b0;
    irq_in = bitv(2) | bitv(4); step();
    irq_in = '0;
    for (int r = 0; r < 4; r++) begin
      wait_valid();
      check("rr_alt_id", irq_id, rr_exp[r]);
      acked = int'(irq_id);
      $display("grant served: id=%0d", irq_id);
      irq_ack = 1'b1; irq_in = bitv(acked);
      step();
      irq_ack = 1'b0; irq_in = '0;
    end
    // Pointer wrap after serving the top channel
    rst = 1'b1; step(); rst = 1'b0;
    mask_we = 1'b1; mask_wdata = '0; step(); mask_we = 1'b0;
    irq_in = bitv(26); step(); irq_in = '0;
    wait_valid();
    check("rr_top_id", irq_id, 26);
    do_ack();
    irq_in = bitv(1) | bitv(25); step(); irq_in = '0;
    wait_valid();
    check("rr_wrap_id", irq_id, 1);
    do_ack();
    step(); step();
    wait_valid();
    do_ack();
`endif

    // Reset while a grant is outstanding
    irq_in = bitv(5); step();
    irq_in = '0; step();
    check("mid_valid", irq_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", irq_valid, 0);
    check("mid_rst_id", irq_id, 0);
    check("mid_rst_mask", mask_q, all_ones);
    check("mid_rst_pend", pending_q, 0);
    step();
    rst = 1'b0;
    step(); step();
    check("post_rst_valid", irq_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
